sprite_line_scheduler: RTL
==========================

SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 8, meaning the number of attribute-table entries (power of 2, 2..16).
REQ-002 SHALL have parameter MAX_PER_LINE, default 4, meaning the maximum number of sprites drawn per line.
REQ-003 SHALL have port i_Clk, input, 1, the single system clock; one clock only, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port i_line_start, input, 1, a one-cycle pulse that starts the back-buffer build for the next line.
REQ-006 SHALL have port i_next_row, input, 10, the beam row being built; sampled on i_line_start.
REQ-007 SHALL have port i_bank, input, 1, the line RAM back-buffer bank; sampled on i_line_start.
REQ-008 SHALL have port i_attr_we, input, 1, the CPU attribute write strobe.
REQ-009 SHALL have port i_attr_idx, input, log2(NUM_SPRITES), the sprite entry index.
REQ-010 SHALL have port i_attr_field, input, 2, the field select: 0=x, 1=y, 2=sprite number, 3=enable.
REQ-011 SHALL have port i_attr_wdata, input, 10, the write data; it is truncated to the field width (x,y 10; num 6; enable 1).
REQ-012 SHALL have ports o_rom_sprite (output, 6), o_rom_row (output, 3) and o_rom_col (output, 3), the SpriteROM address.
REQ-013 SHALL have port i_rom_pixel, input, 2, the SpriteROM data; valid exactly 1 cycle after the address.
REQ-014 SHALL have port o_lr_write, output, 1, the line RAM write strobe.
REQ-015 SHALL have port o_lr_addr, output, 11, the line RAM address = {2'b00, bank, entry[7:0]}.
REQ-016 SHALL have port o_lr_data, output, 2, the line RAM write data.
REQ-017 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.
REQ-018 SHALL have port o_done, output, 1, a one-cycle pulse when a line build completes.
REQ-019 SHALL have port o_overflow, output, 1, high if more than MAX_PER_LINE sprites hit the last scanned line.

Function
REQ-020 FSM SHALL have states IDLE, CLEAR, SCAN, FETCH, DRAW, DONE.
REQ-021 IDLE: on i_line_start SHALL latch row/bank, go CLEAR.
REQ-022 CLEAR: SHALL write 0 to entries 0..255 of the bank, one per cycle (256 cycles), then go SCAN.
REQ-023 SCAN: SHALL evaluate one entry per cycle, index 0..NUM_SPRITES-1; dy = row - y mod 1024; hit = enable && dy < 16.
REQ-024 On a hit with fewer than MAX_PER_LINE slots filled, SHALL snapshot {x[9:1], num, dy[3:1]} into the next slot.
REQ-025 A hit with all slots full SHALL set the overflow flag for this line.
REQ-026 At SCAN end: o_overflow SHALL update, holding until the next SCAN end; 0 slots -> DONE, else -> FETCH on the highest-filled slot.
REQ-027 FETCH/DRAW: per slot, o_rom_* = {num, dy[3:1], c} for c=0..7 on consecutive cycles.
REQ-028 The pixel for c SHALL be written 1 cycle later at entry (x[9:1]+c) mod 256.
REQ-029 A pixel value 0 is transparent and SHALL produce no write (o_lr_write=0).
REQ-030 Slots SHALL be drawn highest-to-lowest so the lowest attribute index wins overlaps.
REQ-031 Each slot SHALL take 9 cycles (8 addresses + 1 drain); slots SHALL be pipelined back-to-back without loss.
REQ-032 DONE: SHALL assert o_done for 1 cycle, then go IDLE.
REQ-033 Worst-case build (MAX_PER_LINE=4, NUM_SPRITES=8) SHALL be 1+256+8+36+1 cycles, which is less than the 800-cycle line.
REQ-034 i_line_start while busy SHALL abort, relatch row/bank and restart at CLEAR; no o_done SHALL be issued for the aborted line.
REQ-035 Attribute writes SHALL apply next cycle; slots already snapshotted SHALL be unaffected; an entry written while being scanned SHALL be evaluated with its old value.
REQ-036 In IDLE, o_lr_write SHALL be 0 and o_rom_* SHALL hold the last value.

Reset
REQ-037 Reset SHALL force state=IDLE; o_busy, o_done, o_overflow, o_lr_write = 0; o_lr_addr, o_lr_data, o_rom_* = 0.
REQ-038 Reset SHALL clear all attribute enables to 0 (x, y, num = 0).
REQ-039 Reset mid-build SHALL abandon the line immediately with no further line RAM writes.

Structure
REQ-040 Package sprite_pkg SHALL hold the field codes, SPRITE_W=16, LR_ENTRIES=256, the state enum and MAX_PER_LINE.
REQ-041 Sub-module sprite_attr_table SHALL hold the NUM_SPRITES-entry register file (CPU write port, scan read port).
REQ-042 The SpriteROM and LineRAM SHALL remain external, connected through ports.

Verification
REQ-043 Sprite 0 at x=40, y=100, num=5, enabled; row=100 -> clear, then writes at entries 20..27 of bank (ROM rows 0), skipping zero pixels; o_done at cycle 1+256+8+9+1.
REQ-044 Row=116, same sprite -> dy=16, no hit; only the 256 clear writes occur; o_done follows.
REQ-045 Six sprites enabled with y=0; row=5 -> slots for indices 0..3 only, o_overflow=1; the next line with 1 hit -> o_overflow=0.
REQ-046 Sprites 0 and 1 both at x=10 with different opaque patterns -> the final entry 5 holds sprite 0's pixel.
REQ-047 x=508 -> entries 254, 255, 0..5 are written (wrap); y=1020 with row=3 -> dy=7 is a hit.
REQ-048 i_line_start at cycle 100 of a build -> restart at CLEAR with no o_done for the aborted line; reset asserted mid-DRAW -> o_lr_write drops the same cycle and all enables read 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line scheduler: field codes, sizes, FSM states, records.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sprite_pkg;

   localparam logic [1:0] FLD_X   = 2'd0;
   localparam logic [1:0] FLD_Y   = 2'd1;
   localparam logic [1:0] FLD_NUM = 2'd2;
   localparam logic [1:0] FLD_EN  = 2'd3;

   localparam int SPRITE_W     = 16;
   localparam int LR_ENTRIES   = 256;
   localparam int MAX_PER_LINE = 4;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SCAN,
      FETCH,
      DRAW,
      DONE
   } state_t;

   // One attribute-table entry as written by the CPU.
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [5:0] num;
      logic       en;
   } attr_t;

   // Per-line snapshot of a hit sprite: half-resolution x, sprite number, ROM row.
   typedef struct packed {
      logic [8:0] xh;
      logic [5:0] num;
      logic [2:0] row;
   } slot_t;

endpackage

// File: rtl/sprite_attr_table.sv
// Sprite attribute register file: one CPU field-write port, one combinational scan read port.
// Latency: writes visible on the read port the cycle after the strobe; reads are same-cycle.
// Backpressure: none; writes are always accepted.
module sprite_attr_table
   import sprite_pkg::*;
#(
   parameter  int NUM_SPRITES = 8,
   localparam int IDX_W       = $clog2(NUM_SPRITES)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [1:0]       field,
   input  logic [9:0]       wdata,
   input  logic [IDX_W-1:0] rd_idx,
   output attr_t            rd_attr
);

   attr_t entry_q [NUM_SPRITES];

   // Field-granular CPU writes; reset disables every sprite and zeroes its fields.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) entry_q[i] <= '0;
      end else if (we) begin
         case (field)
            FLD_X:   entry_q[idx].x   <= wdata;
            FLD_Y:   entry_q[idx].y   <= wdata;
            FLD_NUM: entry_q[idx].num <= wdata[5:0];
            default: entry_q[idx].en  <= wdata[0];
         endcase
      end
   end

   assign rd_attr = entry_q[rd_idx];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Builds one line of sprite pixels into the line RAM back buffer: clear, scan, fetch/draw.
// Latency: 1+256+NUM_SPRITES+9*hits+1 cycles from i_line_start to o_done; ROM data used 1 cycle after address.
// Backpressure: none; i_line_start while busy aborts the build and restarts at CLEAR.
module sprite_line_scheduler #(
   parameter int NUM_SPRITES  = 8,
   parameter int MAX_PER_LINE = sprite_pkg::MAX_PER_LINE
) (
   input  logic                           i_Clk,
   input  logic                           reset,
   input  logic                           i_line_start,
   input  logic [9:0]                     i_next_row,
   input  logic                           i_bank,
   input  logic                           i_attr_we,
   input  logic [$clog2(NUM_SPRITES)-1:0] i_attr_idx,
   input  logic [1:0]                     i_attr_field,
   input  logic [9:0]                     i_attr_wdata,
   output logic [5:0]                     o_rom_sprite,
   output logic [2:0]                     o_rom_row,
   output logic [2:0]                     o_rom_col,
   input  logic [1:0]                     i_rom_pixel,
   output logic                           o_lr_write,
   output logic [10:0]                    o_lr_addr,
   output logic [1:0]                     o_lr_data,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_overflow
);
   import sprite_pkg::*;

   localparam int IDX_W  = $clog2(NUM_SPRITES);
   localparam int SIDX_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
   localparam int FILL_W = $clog2(MAX_PER_LINE + 1);

   state_t            state_q, state_nxt;
   logic [9:0]        row_q;
   logic              bank_q;
   logic [7:0]        clr_q;
   logic [IDX_W-1:0]  scan_q;
   logic [FILL_W-1:0] fill_q, fill_after;
   logic              ovf_line_q, ovf_q;
   slot_t             slot_q [MAX_PER_LINE];
   logic [SIDX_W-1:0] cur_q;
   logic [2:0]        col_q;
   logic              pend_vld_q;
   logic [7:0]        pend_addr_q;
   logic [5:0]        rom_sprite_q;
   logic [2:0]        rom_row_q, rom_col_q;

   attr_t             scan_attr;
   slot_t             cur_slot;
   logic [9:0]        dy;
   logic              hit, slots_full, slot_wr, scan_last;
   logic              spare_unused;

   sprite_attr_table #(.NUM_SPRITES(NUM_SPRITES)) u_attr (
      .clock   (i_Clk),
      .reset   (reset),
      .we      (i_attr_we),
      .idx     (i_attr_idx),
      .field   (i_attr_field),
      .wdata   (i_attr_wdata),
      .rd_idx  (scan_q),
      .rd_attr (scan_attr)
   );

   assign dy         = row_q - scan_attr.y;
   assign hit        = scan_attr.en && (dy < 10'(SPRITE_W));
   assign slots_full = (fill_q == FILL_W'(MAX_PER_LINE));
   assign slot_wr    = (state_q == SCAN) && hit && !slots_full;
   assign fill_after = fill_q + FILL_W'(slot_wr);
   assign scan_last  = (scan_q == IDX_W'(NUM_SPRITES - 1));
   assign cur_slot   = slot_q[cur_q];
   // x LSB is finer than a line RAM entry, and entries wrap mod 256, so these bits have no consumer.
   assign spare_unused = ^{scan_attr.x[0], cur_slot.xh[8]};

   // ROM address is live while fetching and otherwise holds the last fetched address.
   assign o_rom_sprite = (state_q == FETCH) ? cur_slot.num : rom_sprite_q;
   assign o_rom_row    = (state_q == FETCH) ? cur_slot.row : rom_row_q;
   assign o_rom_col    = (state_q == FETCH) ? col_q        : rom_col_q;
   assign o_busy       = (state_q != IDLE);
   assign o_done       = (state_q == DONE);
   assign o_overflow   = ovf_q;

   // State register.
   always_ff @(posedge i_Clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_nxt;
   end

   // Next state and line RAM write port; clear writes take priority over a stale pixel.
   always_comb begin
      state_nxt  = state_q;
      o_lr_write = 1'b0;
      o_lr_addr  = '0;
      o_lr_data  = '0;
      case (state_q)
         IDLE:    state_nxt = IDLE;
         CLEAR:   if (clr_q == 8'(LR_ENTRIES - 1)) state_nxt = SCAN;
         SCAN:    if (scan_last) state_nxt = (fill_after == '0) ? DONE : FETCH;
         FETCH:   if (col_q == 3'd7) state_nxt = DRAW;
         DRAW:    state_nxt = (cur_q == '0) ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (i_line_start) state_nxt = CLEAR;

      if (state_q == CLEAR) begin
         o_lr_write = 1'b1;
         o_lr_addr  = {2'b00, bank_q, clr_q};
      end else if (pend_vld_q) begin
         o_lr_write = (i_rom_pixel != 2'b00);
         o_lr_addr  = {2'b00, bank_q, pend_addr_q};
         o_lr_data  = i_rom_pixel;
      end
   end

   // Build datapath: counters, slot snapshots, overflow flag and the one-cycle pixel write pipeline.
   always_ff @(posedge i_Clk or posedge reset) begin
      if (reset) begin
         row_q        <= '0;
         bank_q       <= 1'b0;
         clr_q        <= '0;
         scan_q       <= '0;
         fill_q       <= '0;
         ovf_line_q   <= 1'b0;
         ovf_q        <= 1'b0;
         cur_q        <= '0;
         col_q        <= '0;
         pend_vld_q   <= 1'b0;
         pend_addr_q  <= '0;
         rom_sprite_q <= '0;
         rom_row_q    <= '0;
         rom_col_q    <= '0;
         for (int i = 0; i < MAX_PER_LINE; i++) slot_q[i] <= '0;
      end else begin
         pend_vld_q <= 1'b0;
         if (state_q == FETCH) begin
            rom_sprite_q <= cur_slot.num;
            rom_row_q    <= cur_slot.row;
            rom_col_q    <= col_q;
         end
         if (i_line_start) begin
            row_q      <= i_next_row;
            bank_q     <= i_bank;
            clr_q      <= '0;
            scan_q     <= '0;
            fill_q     <= '0;
            ovf_line_q <= 1'b0;
         end else begin
            case (state_q)
               CLEAR: clr_q <= clr_q + 8'd1;
               SCAN: begin
                  scan_q <= scan_q + IDX_W'(1);
                  if (slot_wr) begin
                     slot_q[fill_q[SIDX_W-1:0]] <= slot_t'{xh: scan_attr.x[9:1], num: scan_attr.num, row: dy[3:1]};
                     fill_q <= fill_after;
                  end
                  if (hit && slots_full) ovf_line_q <= 1'b1;
                  if (scan_last) begin
                     ovf_q <= ovf_line_q | (hit && slots_full);
                     cur_q <= SIDX_W'(fill_after - FILL_W'(1));
                     col_q <= '0;
                  end
               end
               FETCH: begin
                  col_q       <= col_q + 3'd1;
                  pend_vld_q  <= 1'b1;
                  pend_addr_q <= cur_slot.xh[7:0] + {5'd0, col_q};
               end
               DRAW: begin
                  cur_q <= cur_q - SIDX_W'(1);
                  col_q <= '0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
